network_bank_out: RTL and testbench
===================================

NETWORK_BANK_OUT -- requirements
Module: network_bank_out

Interface
REQ-001 Parameter data_width, default 24: width of one bank read word and one output lane.
REQ-002 Parameter rd_lat, default 1: bank read latency in cycles from address issue to q valid; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a read was issued to all 8 banks this cycle; sel_0..sel_7 valid.
REQ-006 sel_0..sel_7  input  3 each  sel_k = bank index whose word goes to output lane k; sampled with in_valid.
REQ-007 q0..q7  input  data_width each  bank read data, valid rd_lat cycles after issue.
REQ-008 out_valid  output  1  d_out_0..d_out_7 hold a routed word set.
REQ-009 d_out_0..d_out_7  output  data_width each  routed lane data, registered.
REQ-010 perm_err  output  1  sticky selection-error flag; present only per REQ-027.

Function
REQ-011 The block SHALL delay {in_valid, sel_0..sel_7} through an rd_lat-stage shift register so the selects align with the q data of the same issue.
REQ-012 Delay stages SHALL shift every cycle unconditionally; there is no stall input.
REQ-013 When the aligned valid is 1, d_out_k SHALL load q[aligned sel_k] for every k, and out_valid SHALL be 1 on the next cycle.
REQ-014 When the aligned valid is 0, d_out_0..7 SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 Total latency: in_valid at cycle t -> out_valid and d_out at cycle t+rd_lat+1.
REQ-016 Back-to-back issues (in_valid every cycle) SHALL produce out_valid every cycle at full throughput, each set routed with its own selects.
REQ-017 Selects SHALL be used only as delayed; a sel change while data is in flight SHALL NOT affect earlier issues.
REQ-018 Multiple lanes MAY select the same bank; each such lane SHALL receive that bank's word (broadcast is legal data-path behaviour).
REQ-019 Routing SHALL be a pure index; no arithmetic or width change on data; all 3-bit sel values are valid.

Reset
REQ-020 On rst high, all delay stages, out_valid, and d_out_0..7 SHALL clear to 0 immediately, regardless of clk.
REQ-021 Issues in flight when rst asserts SHALL be discarded; no out_valid for them after rst deasserts.
REQ-022 First in_valid sampled on the first rising edge after rst deasserts SHALL be processed normally.
REQ-023 perm_err (when present) SHALL reset to 0.

Configuration
REQ-024 Macro NETWORK_BANK_OUT_PERM_CHECK_EN controls the selection checker.
REQ-025 When defined: on any cycle the aligned valid is 1 and the 8 aligned selects are not a permutation of 0..7 (any duplicate), perm_err SHALL be set on the next edge, coincident with that set's out_valid.
REQ-026 perm_err SHALL remain 1 until rst; routing is unaffected by the check.
REQ-027 When undefined: port perm_err SHALL NOT exist and no checker logic SHALL be present; all other behaviour identical.

Verification
REQ-028 Identity: rd_lat=1, in_valid=1 at cycle 5, sel_k=k, q_k=100+k at cycle 6 -> cycle 7 out_valid=1, d_out_k=100+k.
REQ-029 Reverse with streaming: sel_k=7-k, in_valid 1 for 4 cycles, q_k=16*n+k for issue n -> 4 consecutive out_valid, d_out_k=16*n+(7-k).
REQ-030 Latency sweep: rd_lat=3, single issue at cycle 10 with sel_k=(k+1) mod 8 -> out_valid only at cycle 14, d_out_7=q0 value present at cycle 13.
REQ-031 Reset mid-flight: rd_lat=2, issue at cycle 4, rst pulse at cycle 5 between edges -> outputs 0 immediately, no out_valid at cycle 7.
REQ-032 Checker (macro defined): sel_0=sel_1=3, others distinct -> perm_err=1 with that out_valid, stays 1 through later valid permutations until rst; macro undefined -> builds without perm_err, same data.

Source files
------------

// File: rtl/network_bank_out_if.sv
// Bus bundle for network_bank_out: the select/read-data inputs and the routed output lanes.
interface network_bank_out_if #(
  parameter int unsigned data_width = 24
);
  logic                  in_valid;
  logic [2:0]            sel_0, sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, sel_7;
  logic [data_width-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic                  out_valid;
  logic [data_width-1:0] d_out_0, d_out_1, d_out_2, d_out_3;
  logic [data_width-1:0] d_out_4, d_out_5, d_out_6, d_out_7;

  modport master (
    output in_valid,
    output sel_0, sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, sel_7,
    output q0, q1, q2, q3, q4, q5, q6, q7,
    input  out_valid,
    input  d_out_0, d_out_1, d_out_2, d_out_3, d_out_4, d_out_5, d_out_6, d_out_7
  );

  modport slave (
    input  in_valid,
    input  sel_0, sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, sel_7,
    input  q0, q1, q2, q3, q4, q5, q6, q7,
    output out_valid,
    output d_out_0, d_out_1, d_out_2, d_out_3, d_out_4, d_out_5, d_out_6, d_out_7
  );
endinterface

// File: rtl/network_bank_out.sv
// Routes 8 bank read words onto 8 output lanes using selects delayed to match bank read latency.
// Optional sticky select-permutation checker: define NETWORK_BANK_OUT_PERM_CHECK_EN.
module network_bank_out #(
  parameter int unsigned data_width = 24,
  parameter int unsigned rd_lat     = 1
) (
  input logic               clk,
  input logic               rst,
  network_bank_out_if.slave bus
`ifdef NETWORK_BANK_OUT_PERM_CHECK_EN
  ,
  output logic              perm_err
`endif
);
  localparam int unsigned NumLanes = 8;
  localparam int unsigned Last     = rd_lat - 1;

  typedef logic [2:0]            sel_t;
  typedef logic [data_width-1:0] word_t;

  logic  valid_pipe_q [rd_lat];
  logic  valid_pipe_d [rd_lat];
  sel_t  sel_pipe_q   [rd_lat][NumLanes];
  sel_t  sel_pipe_d   [rd_lat][NumLanes];
  sel_t  sel_in       [NumLanes];
  word_t q_in         [NumLanes];
  word_t d_out_q      [NumLanes];
  word_t d_out_d      [NumLanes];
  logic  out_valid_q, out_valid_d;
  logic  aligned_valid;

  assign sel_in[0] = bus.sel_0;
  assign sel_in[1] = bus.sel_1;
  assign sel_in[2] = bus.sel_2;
  assign sel_in[3] = bus.sel_3;
  assign sel_in[4] = bus.sel_4;
  assign sel_in[5] = bus.sel_5;
  assign sel_in[6] = bus.sel_6;
  assign sel_in[7] = bus.sel_7;

  assign q_in[0] = bus.q0;
  assign q_in[1] = bus.q1;
  assign q_in[2] = bus.q2;
  assign q_in[3] = bus.q3;
  assign q_in[4] = bus.q4;
  assign q_in[5] = bus.q5;
  assign q_in[6] = bus.q6;
  assign q_in[7] = bus.q7;

  assign aligned_valid = valid_pipe_q[Last];

  // Stage 0 captures the issue; the last stage lines up with that issue's bank data.
  always_comb begin
    valid_pipe_d[0] = bus.in_valid;
    for (int k = 0; k < NumLanes; k++) sel_pipe_d[0][k] = sel_in[k];
    for (int i = 1; i < rd_lat; i++) begin
      valid_pipe_d[i] = valid_pipe_q[i-1];
      for (int k = 0; k < NumLanes; k++) sel_pipe_d[i][k] = sel_pipe_q[i-1][k];
    end
  end

  always_comb begin
    out_valid_d = aligned_valid;
    for (int k = 0; k < NumLanes; k++) begin
      d_out_d[k] = d_out_q[k];
      if (aligned_valid) d_out_d[k] = q_in[sel_pipe_q[Last][k]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      for (int i = 0; i < rd_lat; i++) begin
        valid_pipe_q[i] <= 1'b0;
        for (int k = 0; k < NumLanes; k++) sel_pipe_q[i][k] <= '0;
      end
      for (int k = 0; k < NumLanes; k++) d_out_q[k] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      for (int i = 0; i < rd_lat; i++) begin
        valid_pipe_q[i] <= valid_pipe_d[i];
        for (int k = 0; k < NumLanes; k++) sel_pipe_q[i][k] <= sel_pipe_d[i][k];
      end
      for (int k = 0; k < NumLanes; k++) d_out_q[k] <= d_out_d[k];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d_out_0   = d_out_q[0];
  assign bus.d_out_1   = d_out_q[1];
  assign bus.d_out_2   = d_out_q[2];
  assign bus.d_out_3   = d_out_q[3];
  assign bus.d_out_4   = d_out_q[4];
  assign bus.d_out_5   = d_out_q[5];
  assign bus.d_out_6   = d_out_q[6];
  assign bus.d_out_7   = d_out_q[7];

`ifdef NETWORK_BANK_OUT_PERM_CHECK_EN
  logic [NumLanes-1:0] seen;
  logic                perm_err_q, perm_err_d;

  // Eight selects form a permutation exactly when every bank index is hit.
  always_comb begin
    seen = '0;
    for (int k = 0; k < NumLanes; k++) seen[sel_pipe_q[Last][k]] = 1'b1;
    perm_err_d = perm_err_q | (aligned_valid & ~(&seen));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perm_err_q <= 1'b0;
    else     perm_err_q <= perm_err_d;
  end

  assign perm_err = perm_err_q;
`endif
endmodule

// File: tb/tb_network_bank_out.sv
// Randomized bench: drives four DUTs (rd_lat 1..4) with shared stimulus against a per-cycle history model.
module tb_network_bank_out;
  localparam int unsigned Dw     = 24;
  localparam int          NumLat = 4;
  localparam int          MaxCyc = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [2:0]    sel   [8];
  logic [Dw-1:0] q     [8];
  logic          ov    [NumLat];
  logic [Dw-1:0] dout  [NumLat][8];
  logic          perm  [NumLat];

  always #10 clk = ~clk;

  for (genvar g = 0; g < NumLat; g++) begin : g_lat
    network_bank_out_if #(.data_width(Dw)) u_if ();

    assign u_if.in_valid = in_valid;
    assign u_if.sel_0 = sel[0];
    assign u_if.sel_1 = sel[1];
    assign u_if.sel_2 = sel[2];
    assign u_if.sel_3 = sel[3];
    assign u_if.sel_4 = sel[4];
    assign u_if.sel_5 = sel[5];
    assign u_if.sel_6 = sel[6];
    assign u_if.sel_7 = sel[7];
    assign u_if.q0 = q[0];
    assign u_if.q1 = q[1];
    assign u_if.q2 = q[2];
    assign u_if.q3 = q[3];
    assign u_if.q4 = q[4];
    assign u_if.q5 = q[5];
    assign u_if.q6 = q[6];
    assign u_if.q7 = q[7];
    assign ov[g]      = u_if.out_valid;
    assign dout[g][0] = u_if.d_out_0;
    assign dout[g][1] = u_if.d_out_1;
    assign dout[g][2] = u_if.d_out_2;
    assign dout[g][3] = u_if.d_out_3;
    assign dout[g][4] = u_if.d_out_4;
    assign dout[g][5] = u_if.d_out_5;
    assign dout[g][6] = u_if.d_out_6;
    assign dout[g][7] = u_if.d_out_7;

    network_bank_out #(
      .data_width(Dw),
      .rd_lat    (g + 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (u_if.slave)
`ifdef NETWORK_BANK_OUT_PERM_CHECK_EN
      ,
      .perm_err(perm[g])
`endif
    );
`ifndef NETWORK_BANK_OUT_PERM_CHECK_EN
    assign perm[g] = 1'b0;
`endif
  end

  int n_tests = 0;
  int n_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: remember what was presented each cycle and derive each output from that.
  bit            iv_hist  [MaxCyc];
  logic [2:0]    sel_hist [MaxCyc][8];
  logic [Dw-1:0] q_hist   [MaxCyc][8];
  logic [Dw-1:0] exp_d    [NumLat][8];
  bit            exp_perm [NumLat];
  int            cyc = 0;

  bit            nxt_iv;
  logic [2:0]    nxt_sel [8];
  logic [Dw-1:0] nxt_q   [8];

  function automatic bit is_perm(input int t);
    int cnt [8];
    for (int v = 0; v < 8; v++) cnt[v] = 0;
    for (int k = 0; k < 8; k++) cnt[sel_hist[t][k]]++;
    for (int v = 0; v < 8; v++) if (cnt[v] != 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all_zero(input string why);
    for (int g = 0; g < NumLat; g++) begin
      check_eq($sformatf("%s L%0d out_valid", why, g + 1), 64'(ov[g]), 64'd0);
      for (int k = 0; k < 8; k++)
        check_eq($sformatf("%s L%0d d_out_%0d", why, g + 1, k), 64'(dout[g][k]), 64'd0);
`ifdef NETWORK_BANK_OUT_PERM_CHECK_EN
      check_eq($sformatf("%s L%0d perm_err", why, g + 1), 64'(perm[g]), 64'd0);
`endif
    end
  endtask

  task automatic check_outputs();
    for (int g = 0; g < NumLat; g++) begin
      int lat = g + 1;
      int t   = cyc - lat - 1;
      bit ev  = (t >= 0) && iv_hist[t];
      if (ev) begin
        for (int k = 0; k < 8; k++) exp_d[g][k] = q_hist[t + lat][sel_hist[t][k]];
        if (!is_perm(t)) exp_perm[g] = 1'b1;
      end
      check_eq($sformatf("c%0d L%0d out_valid", cyc, lat), 64'(ov[g]), 64'(ev));
      for (int k = 0; k < 8; k++)
        check_eq($sformatf("c%0d L%0d d_out_%0d", cyc, lat, k), 64'(dout[g][k]),
                 64'(exp_d[g][k]));
`ifdef NETWORK_BANK_OUT_PERM_CHECK_EN
      check_eq($sformatf("c%0d L%0d perm_err", cyc, lat), 64'(perm[g]), 64'(exp_perm[g]));
`endif
    end
  endtask

  // One cycle: present nxt_* after the edge, optionally pulse reset between edges, check at negedge.
  task automatic step(input bit pulse_rst);
    @(posedge clk);
    cyc++;
    #1;
    in_valid = nxt_iv;
    for (int k = 0; k < 8; k++) begin
      sel[k] = nxt_sel[k];
      q[k]   = nxt_q[k];
      sel_hist[cyc][k] = nxt_sel[k];
      q_hist[cyc][k]   = nxt_q[k];
    end
    iv_hist[cyc] = nxt_iv;
    if (pulse_rst) begin
      #2 rst = 1'b1;
      #1 check_all_zero($sformatf("c%0d async_rst", cyc));
      #2 rst = 1'b0;
      for (int t = 0; t < cyc; t++) iv_hist[t] = 1'b0;
      for (int g = 0; g < NumLat; g++) begin
        exp_perm[g] = 1'b0;
        for (int k = 0; k < 8; k++) exp_d[g][k] = '0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_q();
    for (int k = 0; k < 8; k++) nxt_q[k] = Dw'($urandom);
  endtask

  task automatic shuffle_sel();
    for (int k = 0; k < 8; k++) nxt_sel[k] = 3'(k);
    for (int k = 7; k > 0; k--) begin
      int j = $urandom_range(k, 0);
      logic [2:0] tmp = nxt_sel[k];
      nxt_sel[k] = nxt_sel[j];
      nxt_sel[j] = tmp;
    end
  endtask

  task automatic idle(input int n);
    nxt_iv = 1'b0;
    for (int i = 0; i < n; i++) begin
      rand_q();
      step(1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      sel[k] = '0; q[k] = '0; nxt_sel[k] = '0; nxt_q[k] = '0;
    end
    for (int g = 0; g < NumLat; g++) begin
      exp_perm[g] = 1'b0;
      for (int k = 0; k < 8; k++) exp_d[g][k] = '0;
    end
    nxt_iv = 1'b0;
    #4 check_all_zero("reset_state");
    #1 rst = 1'b0;

    idle(4);

    // Identity: issue at cycle 5, bank data 100+k afterwards.
    nxt_iv = 1'b1;
    for (int k = 0; k < 8; k++) nxt_sel[k] = 3'(k);
    rand_q();
    step(1'b0);
    nxt_iv = 1'b0;
    for (int k = 0; k < 8; k++) nxt_q[k] = Dw'(100 + k);
    for (int i = 0; i < 6; i++) step(1'b0);

    // Reverse selects, four back-to-back issues, bank data 16*n+k.
    for (int n = 0; n < 10; n++) begin
      nxt_iv = (n < 4);
      for (int k = 0; k < 8; k++) begin
        nxt_sel[k] = (n < 4) ? 3'(7 - k) : 3'($urandom);
        nxt_q[k]   = Dw'(16 * n + k);
      end
      step(1'b0);
    end

    // Single rotated issue, then sels change while it is in flight.
    nxt_iv = 1'b1;
    for (int k = 0; k < 8; k++) nxt_sel[k] = 3'((k + 1) % 8);
    rand_q();
    step(1'b0);
    nxt_iv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) nxt_sel[k] = 3'($urandom);
      rand_q();
      step(1'b0);
    end

    // Reset pulse with an issue in flight.
    nxt_iv = 1'b1;
    shuffle_sel();
    rand_q();
    step(1'b0);
    nxt_iv = 1'b0;
    rand_q();
    step(1'b1);
    idle(6);

    // Duplicate select, then only valid permutations: error flag must stick until reset.
    nxt_iv = 1'b1;
    nxt_sel[0] = 3'd3; nxt_sel[1] = 3'd3;
    nxt_sel[2] = 3'd0; nxt_sel[3] = 3'd1; nxt_sel[4] = 3'd2;
    nxt_sel[5] = 3'd4; nxt_sel[6] = 3'd5; nxt_sel[7] = 3'd6;
    rand_q();
    step(1'b0);
    for (int i = 0; i < 8; i++) begin
      shuffle_sel();
      rand_q();
      step(1'b0);
    end
    nxt_iv = 1'b0;
    rand_q();
    step(1'b1);
    idle(6);

    // Random traffic with occasional mid-flight resets.
    for (int i = 0; i < 300; i++) begin
      nxt_iv = ($urandom_range(9, 0) < 7);
      if ($urandom_range(1, 0) == 0) shuffle_sel();
      else for (int k = 0; k < 8; k++) nxt_sel[k] = 3'($urandom);
      rand_q();
      step($urandom_range(39, 0) == 0);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
